// File: rtl/led_rx_decoder.sv
// WS2812-style single-wire receiver: pulse-width bit decode, 24-bit word assembly, latch detect.
// Optional build macro LED_RX_PULSE_CHECK_EN rejects pulses outside [MIN_HIGH, MAX_HIGH].
//
// state | meaning
// SYNC  | waiting for RESET_CYCLES of low before trusting the line
// IDLE  | synchronised, waiting for the first rising edge of a bit
// HIGH  | measuring the high part of a bit
// LOW   | measuring the low gap after a bit (next bit or latch)
module led_rx_decoder #(
    parameter int THRESH       = 13,
    parameter int RESET_CYCLES = 2400,
    parameter int CNT_W        = 12,
    parameter int MIN_HIGH     = 3,
    parameter int MAX_HIGH     = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] rgb,
    output logic        valid,
    output logic        latch,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RST_C   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] TH_C    = CNT_W'(THRESH);

    state_t           state_q, state_d;
    logic             s1_q, din_s_q, din_d_q;
    logic [CNT_W-1:0] hc_q, hc_d, lc_q, lc_d, hc_inc, lc_inc;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [22:0]      sreg_q, sreg_d;
    logic             got_q, got_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             valid_q, valid_d, latch_q, latch_d, err_q, err_d, busy_q, busy_d;
    logic             bit_v, pulse_bad;

    assign hc_inc = (hc_q == CNT_MAX) ? hc_q : hc_q + 1'b1;
    assign lc_inc = (lc_q == CNT_MAX) ? lc_q : lc_q + 1'b1;
    assign bit_v  = (hc_q >= TH_C);

`ifdef LED_RX_PULSE_CHECK_EN
    assign pulse_bad = (hc_q < CNT_W'(MIN_HIGH)) || (hc_q > CNT_W'(MAX_HIGH));
`else
    assign pulse_bad = 1'b0;
`endif

    // The FSM runs on the delayed copy of din_s, so a level seen here is already an edge.
    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        lc_d      = lc_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        got_d     = got_q;
        rgb_d     = rgb_q;
        valid_d   = 1'b0;
        latch_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            SYNC: begin
                if (din_d_q) begin
                    lc_d = '0;
                end else begin
                    lc_d = lc_inc;
                    if (lc_inc >= RST_C) begin
                        lc_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (din_d_q) begin
                    hc_d    = CNT_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (din_d_q) begin
                    hc_d = hc_inc;
                    if (hc_inc >= RST_C) begin
                        err_d     = 1'b1;
                        hc_d      = '0;
                        lc_d      = '0;
                        bit_cnt_d = '0;
                        sreg_d    = '0;
                        got_d     = 1'b0;
                        state_d   = SYNC;
                    end
                end else if (pulse_bad) begin
                    err_d     = 1'b1;
                    hc_d      = '0;
                    lc_d      = '0;
                    bit_cnt_d = '0;
                    sreg_d    = '0;
                    got_d     = 1'b0;
                    state_d   = SYNC;
                end else begin
                    sreg_d  = {sreg_q[21:0], bit_v};
                    got_d   = 1'b1;
                    lc_d    = CNT_W'(1);
                    state_d = LOW;
                    if (bit_cnt_q == 5'd23) begin
                        rgb_d     = {sreg_q, bit_v};
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            LOW: begin
                if (din_d_q) begin
                    hc_d    = CNT_W'(1);
                    state_d = HIGH;
                end else begin
                    lc_d = lc_inc;
                    if (lc_inc >= RST_C) begin
                        latch_d   = got_q;
                        got_d     = 1'b0;
                        bit_cnt_d = '0;
                        sreg_d    = '0;
                        lc_d      = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            din_s_q   <= 1'b0;
            din_d_q   <= 1'b0;
            state_q   <= SYNC;
            hc_q      <= '0;
            lc_q      <= '0;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            got_q     <= 1'b0;
            rgb_q     <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s1_q      <= din;
            din_s_q   <= s1_q;
            din_d_q   <= din_s_q;
            state_q   <= state_d;
            hc_q      <= hc_d;
            lc_q      <= lc_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            got_q     <= got_d;
            rgb_q     <= rgb_d;
            valid_q   <= valid_d;
            latch_q   <= latch_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rgb   = rgb_q;
    assign valid = valid_q;
    assign latch = latch_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_rx_decoder.sv
// Self-checking bench for led_rx_decoder against a frame-level reference model.
// Honours LED_RX_PULSE_CHECK_EN so the same bench covers both builds.
module tb_led_rx_decoder;
    localparam int THRESH       = 13;
    localparam int RESET_CYCLES = 2400;
    localparam int GAP          = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] rgb;
    logic        valid, latch, busy, err;

    always #5 clk = ~clk;

    led_rx_decoder dut (
        .clk(clk), .rst(rst), .din(din), .rgb(rgb),
        .valid(valid), .latch(latch), .busy(busy), .err(err)
    );

    int ntests = 0, nfail = 0;
    int cyc = 0, valid_cyc = 0, fall_cyc = 0;
    int nlatch = 0, nerr = 0, exp_latch = 0, exp_err = 0;
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];

    // reference model: bits accumulate per frame, 24 bits make a word, a long low ends a frame
    bit          m_sync = 1'b1;
    bit          m_got  = 1'b0;
    int          m_cnt  = 0;
    logic [23:0] m_word = '0;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (valid) begin
            obs_q.push_back(rgb);
            valid_cyc = cyc;
        end
        if (latch) nlatch++;
        if (err) nerr++;
        if (valid && latch) begin
            nfail++;
            $display("FAIL valid_latch_overlap at cycle %0d", cyc);
        end
    end

    task automatic model_pulse(input int hi);
        bit b;
        b = (hi >= THRESH);
`ifdef LED_RX_PULSE_CHECK_EN
        if (!m_sync && (hi < 3 || hi > 30)) begin
            exp_err++;
            m_sync = 1'b1; m_cnt = 0; m_got = 1'b0; m_word = '0;
            return;
        end
`endif
        if (m_sync) return;
        m_word = {m_word[22:0], b};
        m_got  = 1'b1;
        m_cnt++;
        if (m_cnt == 24) begin
            exp_q.push_back(m_word);
            m_cnt = 0;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        model_pulse(hi);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc + 1;
        repeat (lo) @(negedge clk);
    endtask

    task automatic gap(input int n);
        if (!m_sync && m_got) exp_latch++;
        m_sync = 1'b0; m_got = 1'b0; m_cnt = 0;
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input bit rnd);
        logic [23:0] wv;
        int hi, lo;
        wv = w;
        for (int i = 23; i >= 0; i--) begin
            if (rnd) begin
                hi = wv[i] ? $urandom_range(22, 14) : $urandom_range(12, 3);
                lo = $urandom_range(12, 4);
            end else begin
                hi = wv[i] ? 18 : 8;
                lo = wv[i] ? 8 : 18;
            end
            pulse(hi, lo);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); exp_q.delete();
        nlatch = 0; nerr = 0; exp_latch = 0; exp_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if ({rgb, valid, latch, busy, err} !== 28'd0) begin
            nfail++;
            $display("FAIL reset_outputs got rgb=%h v=%b l=%b b=%b e=%b want all 0", rgb, valid, latch, busy, err);
        end
        rst = 1'b0;
        clear_obs();
        m_sync = 1'b1; m_got = 1'b0; m_cnt = 0;
        gap(GAP);
        ntests++;
        if (busy !== 1'b0 || nlatch != 0) begin
            nfail++;
            $display("FAIL sync_no_latch got busy=%b latches=%0d want 0/0", busy, nlatch);
        end
    endtask

    task automatic test_all_ones();
        clear_obs();
        for (int i = 0; i < 24; i++) pulse(18, 8);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'hFFFFFF) begin
            nfail++;
            $display("FAIL ones_word got n=%0d rgb=%h want 1 x ffffff", obs_q.size(), rgb);
        end
        ntests++;
        if (valid_cyc != fall_cyc + 3) begin
            nfail++;
            $display("FAIL ones_latency got cycle %0d want %0d", valid_cyc, fall_cyc + 3);
        end
        ntests++;
        if (nlatch != 1) begin
            nfail++;
            $display("FAIL ones_latch got %0d want 1", nlatch);
        end
    endtask

    task automatic test_pattern();
        clear_obs();
        send_word(24'hA5C300, 1'b0);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'hA5C300 || nerr != 0) begin
            nfail++;
            $display("FAIL pattern got n=%0d rgb=%h err=%0d want 1 x a5c300 err 0", obs_q.size(), rgb, nerr);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_word(24'h123456, 1'b0);
        send_word(24'h00FF00, 1'b0);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 2 || obs_q[0] !== 24'h123456 || obs_q[1] !== 24'h00FF00) begin
            nfail++;
            $display("FAIL b2b_words got n=%0d last=%h want 123456,00ff00", obs_q.size(), rgb);
        end
        ntests++;
        if (nlatch != 1) begin
            nfail++;
            $display("FAIL b2b_latch got %0d want 1", nlatch);
        end
    endtask

    task automatic test_partial();
        clear_obs();
        for (int i = 0; i < 10; i++) pulse(18, 8);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 0 || nlatch != 1) begin
            nfail++;
            $display("FAIL partial got valids=%0d latches=%0d want 0/1", obs_q.size(), nlatch);
        end
        send_word(24'h0000FF, 1'b0);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'h0000FF) begin
            nfail++;
            $display("FAIL after_partial got n=%0d rgb=%h want 1 x 0000ff", obs_q.size(), rgb);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            for (int w = 0; w < 1 + f % 3; w++) send_word(24'($urandom), 1'b1);
            gap(GAP);
            ntests++;
            if (obs_q.size() != exp_q.size()) begin
                nfail++;
                $display("FAIL rand_count frame %0d got %0d want %0d", f, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    ntests++;
                    if (obs_q[i] !== exp_q[i]) begin
                        nfail++;
                        $display("FAIL rand_word frame %0d idx %0d got %h want %h", f, i, obs_q[i], exp_q[i]);
                    end
                end
            end
            ntests++;
            if (nlatch != exp_latch || nerr != exp_err) begin
                nfail++;
                $display("FAIL rand_flags frame %0d got latch=%0d err=%0d want %0d/%0d", f, nlatch, nerr, exp_latch, exp_err);
            end
        end
    endtask

    task automatic test_stuck_high();
        clear_obs();
        din = 1'b1;
        repeat (GAP) @(negedge clk);
        exp_err++;
        m_sync = 1'b1; m_got = 1'b0; m_cnt = 0;
        ntests++;
        if (nerr != exp_err || busy !== 1'b0 || obs_q.size() != 0) begin
            nfail++;
            $display("FAIL stuck_err got err=%0d busy=%b valids=%0d want %0d/0/0", nerr, busy, obs_q.size(), exp_err);
        end
        send_word(24'h5A5A5A, 1'b0);
        ntests++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL stuck_no_resync got valids=%0d want 0", obs_q.size());
        end
        gap(GAP);
        send_word(24'h3C00C3, 1'b0);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'h3C00C3 || nlatch != exp_latch) begin
            nfail++;
            $display("FAIL stuck_recover got n=%0d rgb=%h latch=%0d want 1 x 3c00c3 latch %0d", obs_q.size(), rgb, nlatch, exp_latch);
        end
    endtask

    task automatic test_short_pulse();
        clear_obs();
        for (int i = 23; i >= 0; i--) pulse((i == 18) ? 2 : 18, 8);
        gap(GAP);
        ntests++;
        if (obs_q.size() != exp_q.size() || (exp_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            nfail++;
            $display("FAIL short_pulse_word got n=%0d rgb=%h want n=%0d", obs_q.size(), rgb, exp_q.size());
        end
        ntests++;
        if (nerr != exp_err || nlatch != exp_latch) begin
            nfail++;
            $display("FAIL short_pulse_flags got err=%0d latch=%0d want %0d/%0d", nerr, nlatch, exp_err, exp_latch);
        end
`ifndef LED_RX_PULSE_CHECK_EN
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'hFBFFFF) begin
            nfail++;
            $display("FAIL short_pulse_as_zero got n=%0d rgb=%h want fbffff", obs_q.size(), rgb);
        end
`endif
    endtask

    task automatic test_mid_reset();
        clear_obs();
        for (int i = 0; i < 5; i++) pulse(18, 8);
        rst = 1'b1;
        @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || rgb !== 24'd0 || valid !== 1'b0) begin
            nfail++;
            $display("FAIL mid_reset got busy=%b rgb=%h valid=%b want 0/0/0", busy, rgb, valid);
        end
        rst = 1'b0;
        m_sync = 1'b1; m_got = 1'b0; m_cnt = 0;
        gap(GAP);
        send_word(24'h0F0F0F, 1'b0);
        gap(GAP);
        ntests++;
        if (obs_q.size() != 1 || obs_q[0] !== 24'h0F0F0F || nlatch != 1) begin
            nfail++;
            $display("FAIL mid_reset_recover got n=%0d rgb=%h latch=%0d want 1 x 0f0f0f latch 1", obs_q.size(), rgb, nlatch);
        end
    endtask

    initial begin
        din = 1'b0;
        rst = 1'b1;
        test_reset();
        test_all_ones();
        test_pattern();
        test_back_to_back();
        test_partial();
        test_random();
        test_stuck_high();
        test_short_pulse();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
